// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - addr_w_of() : register address width derived from the register count
//   - ZERO_IDX    : index of the register that can be hardwired to zero
//   - slice_lo()  : low bit of port k inside a flattened {port N-1 .. port 0} bus
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int ZERO_IDX = 0;

  // A single-register file would give $clog2() == 0, so the width is clamped
  // to 1 to keep every address bus legal.
  function automatic int addr_w_of(input int n_reg);
    return (n_reg > 1) ? $clog2(n_reg) : 1;
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Priority match of one address against all write ports. Among the enabled
// ports whose address equals i_addr, the highest port index supplies o_data.
// The top uses one instance per register (write-enable and write-data for
// storage) and one instance per read port (same-cycle bypass).
//
// Ports:
//   i_we    [N_WR]         write enable per port
//   i_waddr [N_WR*ADDR_W]  flattened write addresses
//   i_wdata [N_WR*DATA_W]  flattened write data
//   i_addr  [ADDR_W]       address to match
//   o_hit                  at least one enabled port targets i_addr
//   o_data  [DATA_W]       data of the highest-index matching port (0 if none)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_WR   = 2
) (
  input  logic [N_WR-1:0]        i_we,
  input  logic [N_WR*ADDR_W-1:0] i_waddr,
  input  logic [N_WR*DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic                   o_hit,
  output logic [DATA_W-1:0]      o_data
);

  // Ascending scan: a later (higher-index) match overwrites an earlier one,
  // which yields the highest-index-wins priority without an explicit encoder.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < N_WR; k++) begin
      if (i_we[k] && (i_waddr[slice_lo(k, ADDR_W) +: ADDR_W] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wdata[slice_lo(k, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Multi-port register file with write-port priority, same-cycle write-to-read
// bypass on every read port and a per-register busy scoreboard used by decode
// to stall on registers whose producer has not yet written back.
//
// Ports:
//   clk       system clock, rising edge
//   arst_n    asynchronous reset, active low; clears registers and busy bits
//   we        [N_WR]         write enable per write port
//   waddr     [N_WR*ADDR_W]  write address per port (port k at k*ADDR_W)
//   wdata     [N_WR*DATA_W]  write data per port (port k at k*DATA_W)
//   raddr     [N_RD*ADDR_W]  read address per port
//   rdata     [N_RD*DATA_W]  read data per port, combinational with bypass
//   set_busy                 mark set_addr as having a pending producer
//   set_addr  [ADDR_W]       register to mark busy
//   rbusy     [N_RD]         busy flag of each read port's register, combinational
//   busy_vec  [N_REG]        registered busy bits
// ---------------------------------------------------------------------------
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_REG    = 32,
  parameter int ADDR_W   = addr_w_of(N_REG),
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_WR-1:0]        we,
  input  logic [N_WR*ADDR_W-1:0] waddr,
  input  logic [N_WR*DATA_W-1:0] wdata,
  input  logic [N_RD*ADDR_W-1:0] raddr,
  output logic [N_RD*DATA_W-1:0] rdata,
  input  logic                   set_busy,
  input  logic [ADDR_W-1:0]      set_addr,
  output logic [N_RD-1:0]        rbusy,
  output logic [N_REG-1:0]       busy_vec
);

  logic [DATA_W-1:0] r_regs [N_REG];
  logic [N_REG-1:0]  r_busy;

  logic [N_REG-1:0]  w_reg_hit;
  logic [N_REG-1:0]  w_reg_we;
  logic [N_REG-1:0]  w_set;
  logic [DATA_W-1:0] w_reg_data [N_REG];

  // Per-register write selection and busy-set decode
  for (genvar r = 0; r < N_REG; r++) begin : g_reg
    // Register 0 is locked when hardwired to zero: no writes, never busy.
    localparam bit LOCKED = (ZERO_REG != 0) && (r == ZERO_IDX);

    regfile_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N_WR   (N_WR)
    ) u_wr_arb (
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_addr  (ADDR_W'(r)),
      .o_hit   (w_reg_hit[r]),
      .o_data  (w_reg_data[r])
    );

    assign w_reg_we[r] = w_reg_hit[r] & ~LOCKED;
    assign w_set[r]    = set_busy & (set_addr == ADDR_W'(r)) & ~LOCKED;
  end

  // Storage and busy scoreboard. A set in the same cycle as the retiring
  // write wins: the new producer supersedes the one being written back.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < N_REG; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < N_REG; r++) begin
        if (w_reg_we[r]) begin
          r_regs[r] <= w_reg_data[r];
        end
        if (w_set[r]) begin
          r_busy[r] <= 1'b1;
        end else if (w_reg_we[r]) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = r_busy;

  // Read ports: zero register, then bypass, then storage
  for (genvar j = 0; j < N_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_data;
    logic              w_zero;

    assign w_addr = raddr[slice_lo(j, ADDR_W) +: ADDR_W];

    regfile_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N_WR   (N_WR)
    ) u_byp_arb (
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_addr  (w_addr),
      .o_hit   (w_byp_hit),
      .o_data  (w_byp_data)
    );

    assign w_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_IDX));

    assign rdata[slice_lo(j, DATA_W) +: DATA_W] =
      w_zero    ? '0 :
      w_byp_hit ? w_byp_data :
                  r_regs[w_addr];

    // A retiring write is bypassed, so its register is not reported busy.
    // A locked zero register never matches here because its busy bit stays 0.
    assign rbusy[j] = r_busy[w_addr] & ~w_byp_hit;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
// Self-checking bench for register_file_mp with default parameters
// (DATA_W=16, N_REG=32, N_RD=2, N_WR=2, ZERO_REG=1).
// ---------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int DATA_W = 16;
  localparam int N_REG  = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 2;
  localparam int N_WR   = 2;

  logic                   clk;
  logic                   arst_n;
  logic [N_WR-1:0]        we;
  logic [N_WR*ADDR_W-1:0] waddr;
  logic [N_WR*DATA_W-1:0] wdata;
  logic [N_RD*ADDR_W-1:0] raddr;
  logic [N_RD*DATA_W-1:0] rdata;
  logic                   set_busy;
  logic [ADDR_W-1:0]      set_addr;
  logic [N_RD-1:0]        rbusy;
  logic [N_REG-1:0]       busy_vec;

  register_file_mp #(
    .DATA_W   (DATA_W),
    .N_REG    (N_REG),
    .N_RD     (N_RD),
    .N_WR     (N_WR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .rbusy    (rbusy),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs applied, and the combinational /
  // registered outputs expected before the following rising edge.
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sa;
    logic [15:0] er0, er1;
    logic [1:0]  erb;
    logic [31:0] ebv;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  rbusy;
    logic [31:0] bv;
  } exp_t;

  vec_t vecs [$];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    we = '0; waddr = '0; wdata = '0; set_busy = 1'b0; set_addr = '0;
  endtask

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [15:0] d0,
                              input logic [4:0] a1, input logic [15:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic s, input logic [4:0] sa,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [1:0] eb, input logic [31:0] ebv);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.ra0 = r0; v.ra1 = r1; v.sb = s; v.sa = sa;
    v.er0 = e0; v.er1 = e1; v.erb = eb; v.ebv = ebv;
    return v;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    drive_idle();
    raddr  = '0;
    arst_n = 1'b0;

    // Reset: every address reads zero on both ports
    for (int a = 0; a < N_REG; a++) begin
      raddr = {5'(N_REG - 1 - a), 5'(a)};
      #1;
      check($sformatf("rst_rdata_a%0d", a), 32'(rdata), 32'h0);
      check($sformatf("rst_rbusy_a%0d", a), 32'(rbusy), 32'h0);
    end
    check("rst_busy_vec", busy_vec, 32'h0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("post_rst_rdata", 32'(rdata), 32'h0);
    check("post_rst_busy_vec", busy_vec, 32'h0);

    //            we    wa0  wd0       wa1  wd1       ra0 ra1 sb sa  er0       er1       erb    ebv
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    0,  1, 0, 0, 16'h0,    16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b01, 5, 16'h1234, 0, 16'h0,    5,  6, 0, 0, 16'h1234, 16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    5,  6, 0, 0, 16'h1234, 16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b11, 7, 16'hAAAA, 7, 16'h5555, 7,  7, 0, 0, 16'h5555, 16'h5555, 2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    7,  5, 0, 0, 16'h5555, 16'h1234, 2'b00, 32'h0));
    vecs.push_back(mk(2'b01, 0, 16'hFFFF, 0, 16'h0,    0,  0, 1, 0, 16'h0,    16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    0,  0, 0, 0, 16'h0,    16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    3,  3, 1, 3, 16'h0,    16'h0,    2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    3,  5, 0, 0, 16'h0,    16'h1234, 2'b01, 32'h8));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    3,  5, 0, 0, 16'h0,    16'h1234, 2'b01, 32'h8));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    3,  5, 0, 0, 16'h0,    16'h1234, 2'b01, 32'h8));
    vecs.push_back(mk(2'b10, 0, 16'h0,    3, 16'h00C3, 3,  3, 0, 0, 16'h00C3, 16'h00C3, 2'b00, 32'h8));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    3,  3, 0, 0, 16'h00C3, 16'h00C3, 2'b00, 32'h0));
    vecs.push_back(mk(2'b01, 9, 16'h0909, 0, 16'h0,    9,  9, 1, 9, 16'h0909, 16'h0909, 2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,    9,  9, 0, 0, 16'h0909, 16'h0909, 2'b11, 32'h200));
    vecs.push_back(mk(2'b01, 12,16'hBEEF, 0, 16'h0,   12, 12, 0, 0, 16'hBEEF, 16'hBEEF, 2'b00, 32'h200));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,   12,  7, 0, 0, 16'hBEEF, 16'h5555, 2'b00, 32'h200));
    vecs.push_back(mk(2'b10, 0, 16'h0,   31, 16'h7FFF,31, 30, 0, 0, 16'h7FFF, 16'h0,    2'b00, 32'h200));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,   31,  9, 0, 0, 16'h7FFF, 16'h0909, 2'b10, 32'h200));
    // Lower port hits the read address, higher port writes elsewhere
    vecs.push_back(mk(2'b11, 20,16'h1111, 21, 16'h2222,20, 21, 0, 0, 16'h1111, 16'h2222, 2'b00, 32'h200));
    vecs.push_back(mk(2'b00, 0, 16'h0,    0, 16'h0,   21, 20, 0, 0, 16'h2222, 16'h1111, 2'b00, 32'h200));

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      we       = v.we;
      waddr    = {v.wa1, v.wa0};
      wdata    = {v.wd1, v.wd0};
      raddr    = {v.ra1, v.ra0};
      set_busy = v.sb;
      set_addr = v.sa;
      e.rdata  = {v.er1, v.er0};
      e.rbusy  = v.erb;
      e.bv     = v.ebv;
      sb_q.push_back(e);
      #2;
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_scoreboard_empty", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_rdata", i), 32'(rdata), e.rdata);
        check($sformatf("v%0d_rbusy", i), 32'(rbusy), 32'(e.rbusy));
        check($sformatf("v%0d_busy_vec", i), busy_vec, e.bv);
      end
    end

    // Mid-cycle asynchronous reset discards r9 and its busy bit at once
    @(negedge clk);
    drive_idle();
    raddr = {5'd9, 5'd9};
    #1;
    check("pre_arst_r9", 32'(rdata[15:0]), 32'h0909);
    check("pre_arst_busy_vec", busy_vec, 32'h200);
    arst_n = 1'b0;
    #1;
    check("arst_busy_vec", busy_vec, 32'h0);
    check("arst_rdata", 32'(rdata), 32'h0);
    check("arst_rbusy", 32'(rbusy), 32'h0);

    // A write and set_busy presented while reset is held leave no trace
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {16'h0, 16'h1111};
    set_busy = 1'b1; set_addr = 5'd9;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    arst_n = 1'b1;
    #1;
    check("post_arst_r9", 32'(rdata), 32'h0);
    check("post_arst_busy_vec", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    check("post_arst_r9_edge", 32'(rdata), 32'h0);
    check("post_arst_busy_edge", busy_vec, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read file in the decode stage.
- Configurable depth, width, read-port count and write-port count, with deterministic write-port priority.
- Same-cycle write-to-read bypass on every read port.
- Per-register busy scoreboard, so decode can stall on registers whose producer (load, multi-cycle op) has not yet written back.

Parameters:
DATA_W, 16, data width of each register
N_REG, 32, number of registers; power of two, >= 2
ADDR_W, $clog2(N_REG), register address width (derived; do not override)
N_RD, 2, number of read ports, >= 1
N_WR, 2, number of write ports, >= 1; higher index has priority
ZERO_REG, 1, 1: register 0 is hardwired to zero and never busy; 0: register 0 is an ordinary register

Ports:
clk  in  1  system clock; all state updates on the rising edge
arst_n  in  1  asynchronous reset, active low
we  in  N_WR  write enable per write port
waddr  in  N_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
wdata  in  N_WR*DATA_W  write data; port k occupies bits [k*DATA_W +: DATA_W]
raddr  in  N_RD*ADDR_W  read addresses; port j occupies bits [j*ADDR_W +: ADDR_W]
rdata  out  N_RD*DATA_W  read data per port, combinational
set_busy  in  1  mark register set_addr as having a pending producer
set_addr  in  ADDR_W  register to mark busy
rbusy  out  N_RD  busy flag of the register addressed by each read port, combinational
busy_vec  out  N_REG  registered busy bits, for debug and flush logic

Behaviour:
- Reset (arst_n=0, asynchronous): all registers and all busy bits cleared to 0. Outputs are combinational, so rdata=0, rbusy=0 and busy_vec=0 while reset is asserted and immediately after release.
- Write: on the rising edge, reg[waddr_k] <= wdata_k for every port k with we_k=1.
- Write collision: if several enabled ports target the same address, the highest port index wins. No error is flagged.
- ZERO_REG=1: writes to address 0 are dropped, reads of address 0 return 0, and set_busy to address 0 is ignored.
- Read, 0-cycle latency: rdata_j = wdata of the highest-index port k with we_k=1 and waddr_k==raddr_j (the bypass); otherwise reg[raddr_j]. Address 0 under ZERO_REG=1 always returns 0 and is never bypassed.
- Busy scoreboard, evaluated at each rising edge per register r:
  - set: set_busy=1 and set_addr==r -> busy[r] <= 1
  - else clear: any we_k=1 with waddr_k==r -> busy[r] <= 0
  - else hold
  - Set and write to the same register in the same cycle: set wins, because a new producer supersedes the retiring write. The data is still written.
- rbusy_j = busy[raddr_j] & ~(any we_k with waddr_k==raddr_j). The retiring write is bypassed, so the consumer need not stall that cycle. When set_busy targets raddr_j in the same cycle, it does not affect rbusy_j until the next cycle.
- Reset mid-operation: pending writes and busy bits are discarded, with no partial update.
- Reading an address that is being written on other ports is legal on any number of read ports simultaneously.
- No internal X-propagation. Out-of-range addresses are impossible, since N_REG is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - the ADDR_W derivation function
  - the ZERO_REG index constant (0)
  - port-slice helper functions for the flattened buses
- One sub-module, regfile_wr_arbiter: per-address priority select across the N_WR write ports, producing a write-enable and write-data for each register. It is reused by the bypass path, which performs the same highest-index match against each raddr.
- Busy scoreboard and read muxes stay in the top module.

Test Plan:
1. Reset, then read all addresses on both ports -> rdata=0x0000, rbusy=0, busy_vec=0.
2. Port0 writes r5=0x1234 while raddr_0=5 in the same cycle -> rdata_0=0x1234 (bypass); next cycle, with no write, rdata_0=0x1234 from storage.
3. Port0 writes r7=0xAAAA and port1 writes r7=0x5555 in the same cycle -> bypass and the stored value are both 0x5555.
4. ZERO_REG=1: write r0=0xFFFF and set_busy r0 -> rdata=0x0000, rbusy=0, busy_vec[0]=0.
5. set_busy r3, then 3 idle cycles -> rbusy for raddr=3 is 1. Port1 writes r3=0x00C3 -> same cycle rbusy=0 and rdata=0x00C3; busy_vec[3]=0 next cycle.
6. set_busy r9 and write r9=0x0909 in the same cycle -> busy_vec[9]=1 and r9=0x0909. Then assert arst_n=0 mid-cycle -> busy_vec=0 and r9=0 immediately.
